// File: rtl/instr_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// instr_fetch_ctrl_if : instruction-memory bus, redirect and decode handshake
// Rev 1.0
// ============================================================================
interface instr_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_addr, instr_valid, instr, instr_pc,
    input  imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_addr, instr_valid, instr, instr_pc,
    output imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// instr_fetch_ctrl : PC sequencer with 1-cycle memory latency and 2-entry buffer
// Rev 1.0
// ============================================================================
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          MEM_BYTES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_en,
  output logic                      fetch_err,
  instr_fetch_ctrl_if.master        bus
);

  localparam logic [1:0]  ST_IDLE     = 2'd0;
  localparam logic [1:0]  ST_RUN      = 2'd1;
  localparam logic [1:0]  ST_HALT     = 2'd2;
  localparam logic [32:0] C_MEM_BYTES = 33'(MEM_BYTES);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_infl_pc;
  logic [1:0]  r_count;
  logic [31:0] r_head_pc, r_head_instr;
  logic [31:0] r_tail_pc, r_tail_instr;
  logic        r_err;

  logic        w_run, w_pop, w_push, w_issue;
  logic        w_pc_bad, w_rd_bad, w_err;
  logic [32:0] w_pc_end, w_rd_end;
  logic [2:0]  w_occ;

  // 33-bit end-of-word sums so a PC near 2^32 cannot wrap into range
  assign w_pc_end = {1'b0, r_pc} + 33'd3;
  assign w_rd_end = {1'b0, bus.redirect_pc} + 33'd3;
  assign w_pc_bad = (r_pc[1:0] != 2'b00) || (w_pc_end >= C_MEM_BYTES);
  assign w_rd_bad = (bus.redirect_pc[1:0] != 2'b00) || (w_rd_end >= C_MEM_BYTES);

  assign w_run   = fetch_en && (r_state != ST_HALT);
  assign w_pop   = (r_count != 2'd0) && bus.instr_ready;
  assign w_push  = r_inflight && !bus.redirect_valid;
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_err   = (bus.redirect_valid && w_rd_bad) ||
                   (w_run && !bus.redirect_valid && w_pc_bad);
  assign w_issue = w_run && !bus.redirect_valid && !w_pc_bad && (w_occ < 3'd2);

  assign bus.imem_addr   = r_pc;
  assign bus.instr_valid = (r_count != 2'd0);
  assign bus.instr       = r_head_instr;
  assign bus.instr_pc    = r_head_pc;
  assign fetch_err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_err      <= 1'b0;
      r_pc       <= RESET_PC;
      r_inflight <= 1'b0;
      r_infl_pc  <= 32'd0;
    end else begin
      if (w_err) begin
        r_state <= ST_HALT;
        r_err   <= 1'b1;
      end else if (r_state != ST_HALT) begin
        r_state <= fetch_en ? ST_RUN : ST_IDLE;
      end

      // A faulting redirect target is never loaded, so it never reaches imem_addr
      if (bus.redirect_valid && !w_rd_bad) begin
        r_pc <= bus.redirect_pc;
      end else if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end

      r_inflight <= w_issue;
      if (w_issue) begin
        r_infl_pc <= r_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count      <= 2'd0;
      r_head_pc    <= 32'd0;
      r_head_instr <= 32'd0;
      r_tail_pc    <= 32'd0;
      r_tail_instr <= 32'd0;
    end else if (bus.redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_pc    <= r_infl_pc;
            r_head_instr <= bus.imem_rdata;
          end else begin
            r_tail_pc    <= r_infl_pc;
            r_tail_instr <= bus.imem_rdata;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head_pc    <= r_tail_pc;
          r_head_instr <= r_tail_instr;
          r_count      <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head_pc    <= r_infl_pc;
            r_head_instr <= bus.imem_rdata;
          end else begin
            r_head_pc    <= r_tail_pc;
            r_head_instr <= r_tail_instr;
            r_tail_pc    <= r_infl_pc;
            r_tail_instr <= bus.imem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_ctrl : directed self-checking bench for instr_fetch_ctrl
// Rev 1.0
// ============================================================================
module tb_instr_fetch_ctrl;

  logic clk;
  logic rst_n;
  logic fetch_en;
  logic fetch_err;
  int   checks;
  int   errors;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl #(
    .RESET_PC  (32'd0),
    .MEM_BYTES (256)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .fetch_en  (fetch_en),
    .fetch_err (fetch_err),
    .bus       (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] wexp(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Registered-read memory: word for last cycle's address
  always @(posedge clk) begin
    if (bus.imem_addr <= 32'd252)
      bus.imem_rdata <= wexp(bus.imem_addr);
    else
      bus.imem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    step();
    step();
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", bus.instr_valid);
    end
    checks++;
    if (bus.imem_addr !== 32'd0) begin
      errors++; $display("FAIL reset_addr got %h exp 00000000", bus.imem_addr);
    end
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL reset_err got %b exp 0", fetch_err);
    end
    checks++;
    if (bus.instr !== 32'd0 || bus.instr_pc !== 32'd0) begin
      errors++; $display("FAIL reset_head got %h/%h exp 0/0", bus.instr_pc, bus.instr);
    end
  endtask

  task automatic test_stream();
    rst_n = 1'b1;
    checks++;
    if (bus.imem_addr !== 32'd0) begin
      errors++; $display("FAIL stream_first_addr got %h exp 00000000", bus.imem_addr);
    end
    step();
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL stream_early_valid got %b exp 0", bus.instr_valid);
    end
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4*k) || bus.instr !== wexp(32'(4*k))) begin
        errors++;
        $display("FAIL stream_%0d got v=%b %h/%h exp v=1 %h/%h", k, bus.instr_valid,
                 bus.instr_pc, bus.instr, 32'(4*k), wexp(32'(4*k)));
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [31:0] h;
    h = bus.instr_pc;
    bus.instr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== h || bus.instr !== wexp(h)) begin
        errors++;
        $display("FAIL stall_hold_%0d got v=%b %h/%h exp v=1 %h/%h", c, bus.instr_valid,
                 bus.instr_pc, bus.instr, h, wexp(h));
      end
    end
    checks++;
    if (bus.imem_addr !== h + 32'd8) begin
      errors++; $display("FAIL stall_depth got %h exp %h", bus.imem_addr, h + 32'd8);
    end
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== h + 32'(4*k) || bus.instr !== wexp(h + 32'(4*k))) begin
        errors++;
        $display("FAIL stall_resume_%0d got v=%b %h/%h exp v=1 %h/%h", k, bus.instr_valid,
                 bus.instr_pc, bus.instr, h + 32'(4*k), wexp(h + 32'(4*k)));
      end
      step();
    end
  endtask

  task automatic test_redirect();
    bus.instr_ready = 1'b0;
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL redir_flush1 got %b exp 0", bus.instr_valid);
    end
    bus.instr_ready = 1'b1;
    step();
    checks++;
    if (bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL redir_flush2 got %b exp 0", bus.instr_valid);
    end
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h40 || bus.instr !== wexp(32'h40)) begin
      errors++;
      $display("FAIL redir_target got v=%b %h/%h exp v=1 00000040/%h", bus.instr_valid,
               bus.instr_pc, bus.instr, wexp(32'h40));
    end
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h44 || bus.instr !== wexp(32'h44)) begin
      errors++;
      $display("FAIL redir_next got v=%b %h/%h exp v=1 00000044/%h", bus.instr_valid,
               bus.instr_pc, bus.instr, wexp(32'h44));
    end
  endtask

  task automatic test_bad_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h42;
    step();
    bus.redirect_valid = 1'b0;
    checks++;
    if (fetch_err !== 1'b1) begin
      errors++; $display("FAIL badredir_err got %b exp 1", fetch_err);
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.instr_valid !== 1'b0 || bus.imem_addr === 32'h42 || fetch_err !== 1'b1) begin
        errors++;
        $display("FAIL badredir_halt_%0d got v=%b addr=%h err=%b exp v=0 addr!=42 err=1", c,
                 bus.instr_valid, bus.imem_addr, fetch_err);
      end
      step();
    end
  endtask

  task automatic test_end_of_mem();
    int n;
    n = 0;
    fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hF0;
    step();
    bus.redirect_valid = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (bus.instr_valid === 1'b1) begin
        checks++;
        if (n >= 4 || bus.instr_pc !== 32'hF0 + 32'(4*n) || bus.instr !== wexp(32'hF0 + 32'(4*n))) begin
          errors++;
          $display("FAIL eom_deliver_%0d got %h/%h exp %h/%h", n, bus.instr_pc, bus.instr,
                   32'hF0 + 32'(4*n), wexp(32'hF0 + 32'(4*n)));
        end
        n++;
      end
      step();
    end
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL eom_count got %0d exp 4", n);
    end
    checks++;
    if (fetch_err !== 1'b1) begin
      errors++; $display("FAIL eom_err got %b exp 1", fetch_err);
    end
  endtask

  task automatic test_async_reset();
    fetch_en = 1'b1;
    bus.instr_ready = 1'b1;
    do_reset();
    repeat (5) step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'd0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL async_rst got v=%b addr=%h err=%b exp v=0 addr=0 err=0",
               bus.instr_valid, bus.imem_addr, fetch_err);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'(4*k) || bus.instr !== wexp(32'(4*k))) begin
        errors++;
        $display("FAIL async_restart_%0d got v=%b %h/%h exp v=1 %h/%h", k, bus.instr_valid,
                 bus.instr_pc, bus.instr, 32'(4*k), wexp(32'(4*k)));
      end
      step();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_bad_redirect();
    test_end_of_mem();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
